// File: rtl/ex_muldiv.sv
// Execute stage for an RV32IM pipeline: single-cycle ALU, branches, jumps and multiply,
// plus an iterative restoring divider that stalls the front end until its result is written back.
module ex_muldiv #(
  parameter int M_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic [31:0] jump_addr_o,
  output logic        jump_en_o,
  output logic        hold_flag_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (32'd0 - v) : v;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm, u_imm, j_imm, b_imm;
  logic [4:0]  shamt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign i_imm  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign u_imm  = {inst_i[31:12], 12'd0};
  assign j_imm  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign b_imm  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign shamt  = op2_i[4:0];

  logic signed [31:0] op1_s, op2_s;
  assign op1_s = op1_i;
  assign op2_s = op2_i;

  // Integer ALU, shared by OP and OP-IMM
  logic        alu_sub;
  logic [31:0] alu_res;

  assign alu_sub = (opcode == OPC_OP) && inst_i[30];

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000:  alu_res = alu_sub ? (op1_i - op2_i) : (op1_i + op2_i);
      3'b001:  alu_res = op1_i << shamt;
      3'b010:  alu_res = {31'd0, (op1_s < op2_s)};
      3'b011:  alu_res = {31'd0, (op1_i < op2_i)};
      3'b100:  alu_res = op1_i ^ op2_i;
      3'b101:  alu_res = inst_i[30] ? 32'(op1_s >>> shamt) : (op1_i >> shamt);
      3'b110:  alu_res = op1_i | op2_i;
      default: alu_res = op1_i & op2_i;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (op1_i == op2_i);
      3'b001:  br_taken = (op1_i != op2_i);
      3'b100:  br_taken = (op1_s < op2_s);
      3'b101:  br_taken = (op1_s >= op2_s);
      3'b110:  br_taken = (op1_i < op2_i);
      3'b111:  br_taken = (op1_i >= op2_i);
      default: br_taken = 1'b0;
    endcase
  end

  // Multiplier: operands widened to 64 bits so the low 64 product bits carry the requested signedness
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic [31:0]        mul_res;

  assign mul_a   = (funct3 == 3'b011) ? {32'd0, op1_i} : {{32{op1_i[31]}}, op1_i};
  assign mul_b   = funct3[1] ? {32'd0, op2_i} : {{32{op2_i[31]}}, op2_i};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (funct3 == 3'b000) ? mul_p[31:0] : mul_p[63:32];

  logic [1:0]  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic        rem_sel_q, rem_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        wen_q, wen_d;

  logic        is_mext, is_div, div_signed;
  logic [31:0] div_a_abs, div_b_abs;
  logic [32:0] step_sh, step_diff;
  logic [31:0] div_result;

  assign is_mext    = (M_EN != 0) && (opcode == OPC_OP) && (funct7 == 7'b0000001);
  assign is_div     = is_mext && funct3[2];
  assign div_signed = ~funct3[0];
  assign div_a_abs  = neg_if(op1_i, div_signed && op1_i[31]);
  assign div_b_abs  = neg_if(op2_i, div_signed && op2_i[31]);

  // One restoring step: a negative trial difference (bit 32) means the shifted remainder is kept
  assign step_sh   = {rem_q, dividend_q[31]};
  assign step_diff = step_sh - {1'b0, divisor_q};

  assign div_result = rem_sel_q  ? neg_if(rem_q, neg_rem_q) :
                      div_zero_q ? 32'hFFFF_FFFF : neg_if(quot_q, neg_quot_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    rem_sel_d  = rem_sel_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          state_d    = S_RUN;
          count_d    = 6'd0;
          dividend_d = div_a_abs;
          divisor_d  = div_b_abs;
          quot_d     = 32'd0;
          rem_d      = 32'd0;
          neg_quot_d = div_signed && (op1_i[31] ^ op2_i[31]) && (op2_i != 32'd0);
          neg_rem_d  = div_signed && op1_i[31];
          div_zero_d = (op2_i == 32'd0);
          rem_sel_d  = funct3[1];
          rd_d       = rd_addr_i;
          wen_d      = reg_wen_i;
        end
      end
      S_RUN: begin
        dividend_d = {dividend_q[30:0], 1'b0};
        if (!step_diff[32]) begin
          rem_d  = step_diff[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = step_sh[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= 6'd0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rem_sel_q  <= 1'b0;
      rd_q       <= 5'd0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      rem_sel_q  <= rem_sel_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
    end
  end

  // Output selection; a cycle in reset drives nothing regardless of what sits on the inputs
  always_comb begin
    rd_addr_o   = 5'd0;
    rd_data_o   = 32'd0;
    rd_wen_o    = 1'b0;
    jump_addr_o = 32'd0;
    jump_en_o   = 1'b0;
    hold_flag_o = 1'b0;
    if (!rst) begin
      case (state_q)
        S_RUN: hold_flag_o = 1'b1;
        S_DONE: begin
          rd_addr_o = rd_q;
          rd_wen_o  = wen_q;
          rd_data_o = div_result;
        end
        default: begin
          case (opcode)
            OPC_LUI: begin
              rd_addr_o = rd_addr_i;
              rd_data_o = u_imm;
              rd_wen_o  = reg_wen_i;
            end
            OPC_AUIPC: begin
              rd_addr_o = rd_addr_i;
              rd_data_o = inst_addr_i + u_imm;
              rd_wen_o  = reg_wen_i;
            end
            OPC_JAL: begin
              rd_addr_o   = rd_addr_i;
              rd_data_o   = inst_addr_i + 32'd4;
              rd_wen_o    = reg_wen_i;
              jump_addr_o = inst_addr_i + j_imm;
              jump_en_o   = 1'b1;
            end
            OPC_JALR: begin
              rd_addr_o   = rd_addr_i;
              rd_data_o   = inst_addr_i + 32'd4;
              rd_wen_o    = reg_wen_i;
              jump_addr_o = (op1_i + i_imm) & ~32'd1;
              jump_en_o   = 1'b1;
            end
            OPC_BRANCH: begin
              jump_addr_o = inst_addr_i + b_imm;
              jump_en_o   = br_taken;
            end
            OPC_OPIMM: begin
              rd_addr_o = rd_addr_i;
              rd_data_o = alu_res;
              rd_wen_o  = reg_wen_i;
            end
            OPC_OP: begin
              if (funct7 == 7'b0000001) begin
                if (is_div) begin
                  rd_addr_o   = rd_addr_i;
                  hold_flag_o = 1'b1;
                end else if (is_mext) begin
                  rd_addr_o = rd_addr_i;
                  rd_data_o = mul_res;
                  rd_wen_o  = reg_wen_i;
                end
              end else begin
                rd_addr_o = rd_addr_i;
                rd_data_o = alu_res;
                rd_wen_o  = reg_wen_i;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: ALU, branch/jump, multiply and divider timing/corner cases.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, jump_addr_o;
  logic        rd_wen_o, jump_en_o, hold_flag_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  ex_muldiv #(.M_EN(1)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o), .hold_flag_o(hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd5, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd3, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic wen);
    inst_i = ins; inst_addr_i = pc; op1_i = a; op2_i = b; rd_addr_i = rd; reg_wen_i = wen;
  endtask

  task automatic nop();
    drive(32'h0000_0013, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  // Apply one instruction for one cycle and leave the sampling point at the following negedge
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic wen);
    @(posedge clk); #1;
    drive(ins, pc, a, b, rd, wen);
    @(negedge clk);
  endtask

  task automatic do_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        output int wb_cyc);
    int holds;
    holds = 0;
    wb_cyc = -1;
    step(enc_r(7'h01, f3), 32'h200, a, b, rd, 1'b1);
    chk({tag, "_c0_wen"}, {31'd0, rd_wen_o}, 32'd0);
    for (int k = 0; k < 60; k++) begin
      if (!hold_flag_o) break;
      holds++;
      @(posedge clk); #1;
      nop();
      @(negedge clk);
    end
    wb_cyc = cyc;
    chk({tag, "_holds"}, holds, 33);
    chk({tag, "_wen"}, {31'd0, rd_wen_o}, 32'd1);
    chk({tag, "_rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
    chk({tag, "_data"}, rd_data_o, exp);
  endtask

  initial begin
    int wb1, wb2, wbs;
    rst = 1'b1;
    drive(enc_r(7'h01, 3'b100), 32'h10, 32'd100, 32'd7, 5'd7, 1'b1);
    @(negedge clk);
    chk("rst_hold", {31'd0, hold_flag_o}, 32'd0);
    chk("rst_wen", {31'd0, rd_wen_o}, 32'd0);
    @(negedge clk);
    chk("rst_data", rd_data_o, 32'd0);
    chk("rst_rd", {27'd0, rd_addr_o}, 32'd0);
    chk("rst_jmp", {31'd0, jump_en_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nop();
    @(negedge clk);
    chk("idle_hold", {31'd0, hold_flag_o}, 32'd0);
    chk("idle_data", rd_data_o, 32'd0);

    step(enc_i(12'hFF9, 3'b000, 7'h13), 32'h0, 32'd5, 32'hFFFF_FFF9, 5'd3, 1'b1);
    chk("addi_data", rd_data_o, 32'hFFFF_FFFE);
    chk("addi_wen", {31'd0, rd_wen_o}, 32'd1);
    chk("addi_rd", {27'd0, rd_addr_o}, 32'd3);

    step(enc_r(7'h20, 3'b101), 32'h0, 32'h8000_0000, 32'd4, 5'd4, 1'b1);
    chk("sra", rd_data_o, 32'hF800_0000);
    step(enc_r(7'h20, 3'b000), 32'h0, 32'd3, 32'd5, 5'd4, 1'b1);
    chk("sub", rd_data_o, 32'hFFFF_FFFE);
    step(enc_i(12'hFFF, 3'b010, 7'h13), 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1);
    chk("slti", rd_data_o, 32'd1);

    step(enc_b(13'h1FF0, 3'b001), 32'h100, 32'd1, 32'd2, 5'd0, 1'b0);
    chk("bne_en", {31'd0, jump_en_o}, 32'd1);
    chk("bne_addr", jump_addr_o, 32'h0000_00F0);
    chk("bne_wen", {31'd0, rd_wen_o}, 32'd0);
    step(enc_b(13'h1FF0, 3'b001), 32'h100, 32'd2, 32'd2, 5'd0, 1'b0);
    chk("bne_nt", {31'd0, jump_en_o}, 32'd0);
    step(enc_b(13'h0010, 3'b110), 32'h100, 32'd1, 32'hFFFF_FFFF, 5'd0, 1'b0);
    chk("bltu_en", {31'd0, jump_en_o}, 32'd1);
    chk("bltu_addr", jump_addr_o, 32'h0000_0110);

    step(enc_i(12'h000, 3'b000, 7'h67), 32'h40, 32'h203, 32'd0, 5'd1, 1'b1);
    chk("jalr_addr", jump_addr_o, 32'h0000_0202);
    chk("jalr_data", rd_data_o, 32'h0000_0044);
    chk("jalr_en", {31'd0, jump_en_o}, 32'd1);
    step(enc_j(21'h000008), 32'h1000, 32'd0, 32'd0, 5'd1, 1'b1);
    chk("jal_addr", jump_addr_o, 32'h0000_1008);
    chk("jal_data", rd_data_o, 32'h0000_1004);
    step({20'hABCDE, 5'd2, 7'h17}, 32'h10, 32'd0, 32'd0, 5'd2, 1'b1);
    chk("auipc", rd_data_o, 32'hABCD_E010);

    step(enc_r(7'h01, 3'b001), 32'h0, 32'h8000_0000, 32'd2, 5'd6, 1'b1);
    chk("mulh", rd_data_o, 32'hFFFF_FFFF);
    chk("mulh_hold", {31'd0, hold_flag_o}, 32'd0);
    step(enc_r(7'h01, 3'b011), 32'h0, 32'h8000_0000, 32'd2, 5'd6, 1'b1);
    chk("mulhu", rd_data_o, 32'd1);
    step(enc_r(7'h01, 3'b000), 32'h0, 32'd7, 32'hFFFF_FFFD, 5'd6, 1'b1);
    chk("mul", rd_data_o, 32'hFFFF_FFEB);
    chk("mul_hold", {31'd0, hold_flag_o}, 32'd0);
    step(enc_r(7'h01, 3'b010), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
    chk("mulhsu", rd_data_o, 32'hFFFF_FFFF);

    do_div("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, wb1);
    do_div("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, wb1);
    do_div("divu0", 3'b101, 32'd9, 32'd0, 5'd8, 32'hFFFF_FFFF, wb1);
    do_div("remu0", 3'b111, 32'd9, 32'd0, 5'd8, 32'd9, wb1);
    do_div("rem0s", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFB, wb1);
    do_div("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, wb1);
    do_div("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, wb1);
    do_div("divu", 3'b101, 32'hFFFF_FFFF, 32'd10, 5'd10, 32'h1999_9999, wb1);

    // Abort: reset lands in cycle 10 of a running division
    step(enc_r(7'h01, 3'b100), 32'h200, 32'd100, 32'd3, 5'd11, 1'b1);
    for (int k = 1; k < 10; k++) step(32'h0000_0013, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("abort_busy", {31'd0, hold_flag_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_hold", {31'd0, hold_flag_o}, 32'd0);
    wbs = 0;
    for (int k = 0; k < 40; k++) begin
      if (rd_wen_o) wbs++;
      @(negedge clk);
    end
    chk("abort_nowb", wbs, 0);

    do_div("b2b1", 3'b100, 32'd100, 32'd7, 5'd12, 32'd14, wb1);
    do_div("b2b2", 3'b110, 32'd100, 32'd7, 5'd13, 32'd2, wb2);
    chk("b2b_gap", wb2 - wb1, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute stage of the RV32I pipeline; sits directly downstream of the ID/EX pipeline register.
- Consumes the registered instruction, PC and operands, and produces the register-file write (rd address, data, enable).
- Produces the jump request for ctrl.
- Adds RV32M: MUL* completes in a single cycle; DIV/DIVU/REM/REMU run on an iterative radix-2 divider that stalls the front end through hold_flag_o.

Parameters:
- M_EN, 1: 1 = decode RV32M; 0 = all funct7=0000001 OP instructions behave as NOP.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_i  in  32  instruction from ID/EX (NOP 32'h00000013 when flushed)
- inst_addr_i  in  32  PC of inst_i
- op1_i  in  32  rs1 value (ignored for LUI/AUIPC/JAL)
- op2_i  in  32  rs2 value for OP/branch; sign-extended I-imm for OP-IMM
- rd_addr_i  in  5  destination register
- reg_wen_i  in  1  destination write enable from decode
- rd_addr_o  out  5  write-back address
- rd_data_o  out  32  write-back data
- rd_wen_o  out  1  write-back enable
- jump_addr_o  out  32  redirect target
- jump_en_o  out  1  redirect request to ctrl (flushes IF/ID, ID/EX)
- hold_flag_o  out  1  stall request to ctrl (freeze PC and IF/ID, insert NOP into ID/EX)

Behaviour:
- Outputs are combinational from inputs and divider state.
- Registered state: busy, 6-bit count, dividend/divisor/quotient/remainder, sign flags, latched op, rd.
- Reset (rst=1 at a clk edge):
  - busy=0, count=0, all datapath registers 0.
  - With busy=0 and a NOP input, all outputs are 0.
  - Reset mid-division aborts with no write-back.
- ALU ops (OP/OP-IMM), write rd_data_o in the same cycle, rd_wen_o=reg_wen_i:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and the immediate forms.
  - Shift amount is op2_i[4:0].
- LUI: rd_data_o = U-imm.
- AUIPC: rd_data_o = inst_addr_i + U-imm.
- JAL: jump_addr_o = inst_addr_i + J-imm; rd_data_o = inst_addr_i + 4.
- JALR: jump_addr_o = (op1_i + I-imm) & ~1; rd_data_o = inst_addr_i + 4.
- Jump enable and immediates:
  - jump_en_o=1 for JAL/JALR.
  - For BEQ/BNE/BLT/BGE/BLTU/BGEU, jump_en_o=1 only when the condition holds; target = inst_addr_i + B-imm.
  - All immediates are decoded from inst_i.
  - Branches never write rd.
- Loads, stores, FENCE, SYSTEM and unknown opcodes: rd_wen_o=0, jump_en_o=0, hold_flag_o=0.
- MUL/MULH/MULHSU/MULHU (M_EN=1):
  - Single cycle, no stall.
  - Result is the low or high 32 bits of the 64-bit product with the specified signedness.
- DIV/DIVU/REM/REMU (M_EN=1), states IDLE -> RUN -> DONE:
  - IDLE, div op seen (cycle C0):
    - Latch absolute-value operands, sign flags, op, rd_addr_i.
    - Enter RUN, count=0.
    - hold_flag_o=1, rd_wen_o=0.
  - RUN (C1..C32): one restoring-division step per cycle, count++; hold_flag_o=1. At count=31 step, go to DONE.
  - DONE (C33):
    - hold_flag_o=0, rd_addr_o=latched rd, rd_wen_o=1, rd_data_o=signed-corrected quotient or remainder.
    - Return to IDLE.
  - Fixed latency 34 cycles from entry to write-back, regardless of operands.
  - While busy, inst_i etc. are ignored (ctrl supplies NOP).
  - In DONE, the NOP present on the inputs produces nothing else.
  - Divisor 0: quotient = 32'hFFFFFFFF; remainder = dividend (signed and unsigned).
  - Signed overflow 32'h80000000 / -1: quotient = 32'h80000000, remainder = 0.
  - Remainder sign follows dividend; quotient sign = xor of signs (non-zero divisor).
  - A div op with rd=x0 or reg_wen_i=0 still runs the full sequence; rd_wen_o in DONE = latched reg_wen_i.
- jump_en_o and hold_flag_o are never both 1 (a div op never jumps).

Test Plan:
- Reset: rst=1 two cycles with a DIV on inputs -> all outputs 0; after release with NOP, busy=0, hold_flag_o=0.
- ALU/jump: ADDI op1=5, op2=-7, rd=3 -> rd_data_o=32'hFFFFFFFE, rd_wen_o=1; BNE at PC 0x100 with op1≠op2 and B-imm -16 -> jump_en_o=1, jump_addr_o=0xF0; JALR op1=0x203, imm 0 at PC 0x40 -> jump_addr_o=0x202, rd_data_o=0x44.
- Multiply: MULH op1=32'h80000000, op2=2 -> rd_data_o=32'hFFFFFFFF; MULHU same operands -> 1; MUL 7*-3 -> 32'hFFFFFFEB, all with hold_flag_o=0.
- Signed divide: DIV -7/2, rd=5, then NOPs -> hold_flag_o=1 for exactly 33 cycles; at cycle 34 rd_wen_o=1, rd_addr_o=5, rd_data_o=-3; REM -7/2 -> -1.
- Corner divides:
  - DIVU 9/0 -> 32'hFFFFFFFF; REMU 9/0 -> 9.
  - DIV 32'h80000000/-1 -> 32'h80000000; REM same operands -> 0.
  - Each at cycle 34.
- Abort and back-to-back: assert rst at cycle 10 of a division -> no write-back, hold_flag_o=0 next cycle. Two DIVs back-to-back (second fed after hold drops) -> two write-backs 34 cycles apart with correct data.
